// File: rtl/booth_acc_pkg.sv
// Shared types and helpers for the Booth product accumulator.
//   state_t : accumulator FSM states (ACC collects products, DONE presents a sum)
//   PW_DEF  : default product width
//   AW_DEF  : default accumulator width
//   sext()  : sign-extends the low pw bits of a 64-bit value to the full 64 bits;
//             callers cast the result down to their accumulator width.
package booth_acc_pkg;

  typedef enum logic {
    ACC  = 1'b0,
    DONE = 1'b1
  } state_t;

  localparam int PW_DEF = 8;
  localparam int AW_DEF = 16;

  function automatic logic signed [63:0] sext(input logic signed [63:0] v, input int pw);
    return (v <<< (64 - pw)) >>> (64 - pw);
  endfunction

endpackage

// File: rtl/booth_acc_add.sv
// Combinational AW-bit signed adder with overflow flag.
//   a, b : signed operands
//   sum  : a + b, wrapped or clamped depending on build
//   ovf  : signed overflow of this addition (operand signs agree, result sign differs)
// Build option: BOOTH_ACC_SATURATE_EN clamps sum to the signed AW range on overflow;
// without it the sum wraps modulo 2^AW and ovf still reports the wrap.
module booth_acc_add #(
  parameter int AW = 16
) (
  input  logic signed [AW-1:0] a,
  input  logic signed [AW-1:0] b,
  output logic signed [AW-1:0] sum,
  output logic                 ovf
);

  logic signed [AW-1:0] raw;

  assign raw = a + b;
  assign ovf = (a[AW-1] == b[AW-1]) && (raw[AW-1] != a[AW-1]);

`ifdef BOOTH_ACC_SATURATE_EN
  // Overflow direction follows the common operand sign.
  function automatic logic signed [AW-1:0] clamp(input logic neg);
    return neg ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
  endfunction

  always_comb begin
    sum = raw;
    if (ovf) sum = clamp(a[AW-1]);
  end
`else
  always_comb begin
    sum = raw;
  end
`endif

endmodule

// File: rtl/booth_product_accumulator.sv
// Sums groups of N_TERMS signed products from the Booth multiplier and hands each
// group sum downstream over a valid/ready handshake.
//   clk, rst_n           : clock, asynchronous active-low reset
//   clear                : synchronous abort of the current group (highest priority)
//   in_valid/in_ready    : product handshake; in_ready is high only while collecting
//   in_product [PW]      : signed product
//   out_valid/out_ready  : sum handshake
//   out_sum [AW]         : signed group sum
//   out_ovf              : an addition in this group overflowed (wrapped or clamped)
// Build option: BOOTH_ACC_SATURATE_EN selects clamping instead of wrapping
// (implemented inside booth_acc_add).
module booth_product_accumulator
  import booth_acc_pkg::*;
#(
  parameter int PW      = PW_DEF,
  parameter int AW      = AW_DEF,
  parameter int N_TERMS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic signed [PW-1:0] in_product,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic signed [AW-1:0] out_sum,
  output logic                 out_ovf
);

  localparam int CW = $clog2(N_TERMS) + 1;

  state_t               state, state_nxt;
  logic signed [AW-1:0] acc;
  logic [CW-1:0]        cnt;
  logic                 ovf_grp;
  logic signed [AW-1:0] ext;
  logic signed [AW-1:0] sum_add;
  logic                 ovf_add;
  logic                 in_beat;
  logic                 out_beat;
  logic                 last;

  assign ext      = AW'(sext(64'(in_product), PW));
  assign in_beat  = in_valid && in_ready;
  assign out_beat = out_valid && out_ready;
  assign last     = (cnt == CW'(N_TERMS - 1));

  booth_acc_add #(.AW(AW)) u_add (
    .a   (acc),
    .b   (ext),
    .sum (sum_add),
    .ovf (ovf_add)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACC;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACC;
    end else begin
      case (state)
        ACC:     if (in_beat && last) state_nxt = DONE;
        DONE:    if (out_beat)        state_nxt = ACC;
        default: state_nxt = ACC;
      endcase
    end
  end

  always_comb begin
    in_ready = (state == ACC);
  end

  // Accumulate stage: running sum plus group overflow, result registered with the last term.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      cnt       <= '0;
      ovf_grp   <= 1'b0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_ovf   <= 1'b0;
    end else if (clear) begin
      acc       <= '0;
      cnt       <= '0;
      ovf_grp   <= 1'b0;
      out_valid <= 1'b0;
      out_ovf   <= 1'b0;
    end else if (in_beat) begin
      if (last) begin
        out_sum   <= sum_add;
        out_ovf   <= ovf_grp | ovf_add;
        out_valid <= 1'b1;
        acc       <= '0;
        cnt       <= '0;
        ovf_grp   <= 1'b0;
      end else begin
        acc     <= sum_add;
        cnt     <= cnt + CW'(1);
        ovf_grp <= ovf_grp | ovf_add;
      end
    end else if (out_beat) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_booth_product_accumulator.sv
module tb_booth_product_accumulator;

  localparam int ND = 3;
  localparam int AWS [ND] = '{16, 10, 16};
  localparam int NTS [ND] = '{4, 8, 1};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic              clr  [ND];
  logic              iv   [ND];
  logic signed [7:0] prod [ND];
  logic              ordy [ND];
  logic              rdy  [ND];
  logic              ov   [ND];
  logic              ovf  [ND];
  logic signed [15:0] sum0;
  logic signed [9:0]  sum1;
  logic signed [15:0] sum2;

  int checks = 0;
  int errors = 0;

  // Model state: products of the open group, and the pending/held result.
  int    q  [ND][$];
  bit    ev [ND];
  longint es [ND];
  bit    eo [ND];

  always #5 clk = ~clk;

  booth_product_accumulator #(.PW(8), .AW(16), .N_TERMS(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .clear(clr[0]), .in_valid(iv[0]), .in_ready(rdy[0]),
    .in_product(prod[0]), .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(sum0), .out_ovf(ovf[0]));

  booth_product_accumulator #(.PW(8), .AW(10), .N_TERMS(8)) dut1 (
    .clk(clk), .rst_n(rst_n), .clear(clr[1]), .in_valid(iv[1]), .in_ready(rdy[1]),
    .in_product(prod[1]), .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(sum1), .out_ovf(ovf[1]));

  booth_product_accumulator #(.PW(8), .AW(16), .N_TERMS(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .clear(clr[2]), .in_valid(iv[2]), .in_ready(rdy[2]),
    .in_product(prod[2]), .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(sum2), .out_ovf(ovf[2]));

  function automatic longint act_sum(int d);
    case (d)
      0:       return longint'(sum0);
      1:       return longint'(sum1);
      default: return longint'(sum2);
    endcase
  endfunction

  task automatic chk(string nm, int d, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d got %0d expected %0d at %0t", nm, d, act, exp, $time);
    end
  endtask

  // Signed sum of the group with per-addition range check, wrap or clamp.
  task automatic fold(int d);
    longint mx = (longint'(1) <<< (AWS[d] - 1)) - 1;
    longint mn = -mx - 1;
    longint span = longint'(1) <<< AWS[d];
    longint a = 0;
    bit o = 1'b0;
    foreach (q[d][i]) begin
      a = a + longint'(q[d][i]);
      if (a > mx || a < mn) begin
        o = 1'b1;
`ifdef BOOTH_ACC_SATURATE_EN
        a = (a > mx) ? mx : mn;
`else
        a = (a > mx) ? a - span : a + span;
`endif
      end
    end
    es[d] = a;
    eo[d] = o;
  endtask

  task automatic model_reset();
    for (int d = 0; d < ND; d++) begin
      q[d].delete();
      ev[d] = 1'b0;
      es[d] = 0;
      eo[d] = 1'b0;
    end
  endtask

  task automatic model_step(int d);
    if (clr[d]) begin
      q[d].delete();
      ev[d] = 1'b0;
      eo[d] = 1'b0;
    end else if (!ev[d]) begin
      if (iv[d]) begin
        q[d].push_back(int'(prod[d]));
        if (q[d].size() == NTS[d]) begin
          fold(d);
          q[d].delete();
          ev[d] = 1'b1;
        end
      end
    end else if (ordy[d]) begin
      ev[d] = 1'b0;
    end
  endtask

  task automatic compare();
    for (int d = 0; d < ND; d++) begin
      chk("in_ready", d, longint'(rdy[d]), longint'(!ev[d]));
      chk("out_valid", d, longint'(ov[d]), longint'(ev[d]));
      chk("out_sum", d, act_sum(d), es[d]);
      chk("out_ovf", d, longint'(ovf[d]), longint'(eo[d]));
    end
  endtask

  // One clock: model follows the edge, outputs compared on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) for (int d = 0; d < ND; d++) model_step(d);
    else model_reset();
    @(negedge clk);
    compare();
  endtask

  task automatic idle_inputs();
    for (int d = 0; d < ND; d++) begin
      clr[d] = 1'b0; iv[d] = 1'b0; prod[d] = '0; ordy[d] = 1'b1;
    end
  endtask

  task automatic feed(int d, logic [7:0] p);
    iv[d] = 1'b1; prod[d] = p;
    step();
    iv[d] = 1'b0;
  endtask

  task automatic feed_group(int d, logic [7:0] a, logic [7:0] b, logic [7:0] c, logic [7:0] e);
    feed(d, a); feed(d, b); feed(d, c); feed(d, e);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    step();
    step();
    chk("lit_reset_ready", 0, longint'(rdy[0]), 1);
    chk("lit_reset_sum", 0, act_sum(0), 0);
    rst_n = 1'b1;
    step();

    // Basic group with out_ready high.
    feed_group(0, 8'h0C, 8'hF4, 8'h31, 8'h07);
    chk("lit_basic_valid", 0, longint'(ov[0]), 1);
    chk("lit_basic_sum", 0, act_sum(0), 56);
    chk("lit_basic_ready_low", 0, longint'(rdy[0]), 0);
    step();
    chk("lit_basic_ready_back", 0, longint'(rdy[0]), 1);

    // Backpressure: result held, extra beats ignored.
    ordy[0] = 1'b0;
    feed_group(0, 8'h0C, 8'hF4, 8'h31, 8'h07);
    for (int i = 0; i < 5; i++) begin
      iv[0] = 1'b1; prod[0] = 8'h55;
      step();
      chk("lit_bp_hold", 0, act_sum(0), 56);
    end
    iv[0] = 1'b0; ordy[0] = 1'b1;
    step();
    feed_group(0, 8'h01, 8'h01, 8'h01, 8'h01);
    chk("lit_bp_next", 0, act_sum(0), 4);
    step();

    // Most negative products.
    feed_group(0, 8'h80, 8'h80, 8'h80, 8'h80);
    chk("lit_neg_sum", 0, act_sum(0), -512);
    chk("lit_neg_ovf", 0, longint'(ovf[0]), 0);
    step();

    // Clear mid-group with a simultaneous beat.
    feed(0, 8'h05); feed(0, 8'h05);
    clr[0] = 1'b1; iv[0] = 1'b1; prod[0] = 8'h05;
    step();
    clr[0] = 1'b0; iv[0] = 1'b0;
    feed_group(0, 8'h02, 8'h02, 8'h02, 8'h02);
    chk("lit_clear_sum", 0, act_sum(0), 8);

    // Asynchronous reset between edges while a result is pending.
    ordy[0] = 1'b0;
    step();
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_valid", 0, longint'(ov[0]), 0);
    chk("lit_async_ready", 0, longint'(rdy[0]), 1);
    model_reset();
    #1 rst_n = 1'b1;
    ordy[0] = 1'b1;
    feed(0, 8'h09); feed(0, 8'h09);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("lit_async_mid_ready", 0, longint'(rdy[0]), 1);
    model_reset();
    #1 rst_n = 1'b1;
    @(negedge clk);
    feed_group(0, 8'h03, 8'h03, 8'h03, 8'h03);
    chk("lit_after_reset_sum", 0, act_sum(0), 12);
    step();

    // Narrow accumulator overflow: 8 x 127 in 10 bits.
    for (int i = 0; i < 8; i++) feed(1, 8'h7F);
`ifdef BOOTH_ACC_SATURATE_EN
    chk("lit_sat_sum", 1, longint'(unsigned'(sum1)), 511);
`else
    chk("lit_wrap_sum", 1, longint'(unsigned'(sum1)), 1016);
`endif
    chk("lit_ovf_flag", 1, longint'(ovf[1]), 1);
    step();

    // Single-term groups.
    feed(2, 8'hFB);
    chk("lit_n1_sum", 2, act_sum(2), -5);
    feed(2, 8'h40);
    chk("lit_n1_dead", 2, longint'(rdy[2]), 1);
    feed(2, 8'h40);
    chk("lit_n1_sum2", 2, act_sum(2), 64);
    step();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
